// File: rtl/reg_arb_pkg.sv
// Shared constants and helpers for the reg_arb round-robin write arbiter.
// Optional feature macro: REG_ARB_LOCK_EN (burst lock for the current owner).
package reg_arb_pkg;

    localparam int unsigned N_DEF         = 4;
    localparam int unsigned W_DEF         = 8;
    localparam int unsigned MAX_BURST_DEF = 4;

    // Upper bound on requesters; onehot() is sized for it and sliced by the user
    localparam int unsigned MAX_N    = 16;
    localparam int unsigned MAX_IDXW = 4;

    // Index width for n requesters (never below one bit)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned IDXW_DEF = idx_w(N_DEF);

    // One-hot decode of a requester index
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDXW-1:0] idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of req & ~excl,
// scanning ptr, ptr+1, ... modulo N.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  logic [N-1:0]    excl,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0]    cand;
    logic [IDXW-1:0] pos;

    assign cand = req & ~excl;

    // Scan from farthest to nearest so the nearest candidate to ptr wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IDXW'((32'(ptr) + 32'(k)) % N);
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/reg_arb.sv
// Round-robin write arbiter for one shared W-bit register.
// Optional feature macro: REG_ARB_LOCK_EN adds the lock port and burst hold.
module reg_arb
    import reg_arb_pkg::*;
#(
    parameter int unsigned N         = N_DEF,
    parameter int unsigned W         = W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [N-1:0]          lock,
`endif
    output logic [N-1:0]          gnt,
    output logic [W-1:0]          q,
    output logic [idx_w(N)-1:0]   q_owner,
    output logic                  q_valid
);

    localparam int unsigned IDXW = idx_w(N);

    if (N < 2 || N > MAX_N || MAX_BURST < 1) begin : g_cfg_err
        $error("reg_arb: unsupported N or MAX_BURST");
    end

    logic [IDXW-1:0] ptr;
    logic [N-1:0]    excl_c;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic            win_c;
    logic            rot_c;
    logic [IDXW-1:0] win_idx_c;
    logic [IDXW-1:0] ptr_nxt_c;
    logic [W-1:0]    win_data_c;

`ifdef REG_ARB_LOCK_EN
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] bcnt;
    logic          own_hold_c;
    logic          lock_win_c;

    // Last cycle's owner still requesting with lock held
    assign own_hold_c = |(gnt & req & lock);
    assign lock_win_c = own_hold_c && (bcnt < BW'(MAX_BURST));
    // Owner that exhausted its burst sits out this one selection
    assign excl_c     = (own_hold_c && !lock_win_c) ? gnt : '0;
`else
    assign excl_c = '0;
`endif

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .excl  (excl_c),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Winner selection: lock hold overrides rotation; excluded owner is a fallback
    always_comb begin
        win_c     = pick_found;
        rot_c     = pick_found;
        win_idx_c = pick_idx;
`ifdef REG_ARB_LOCK_EN
        if (lock_win_c) begin
            win_c     = 1'b1;
            rot_c     = 1'b0;
            win_idx_c = q_owner;
        end else if (!pick_found && own_hold_c) begin
            win_c     = 1'b1;
            rot_c     = 1'b1;
            win_idx_c = q_owner;
        end
`endif
        ptr_nxt_c  = (win_idx_c == IDXW'(N - 1)) ? '0 : win_idx_c + IDXW'(1);
        win_data_c = wdata[32'(win_idx_c) * W +: W];
    end

    // Shared register, owner tag, grant and rotation pointer
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q       <= '0;
            q_owner <= '0;
            q_valid <= 1'b0;
            gnt     <= '0;
            ptr     <= '0;
        end else if (win_c) begin
            q       <= win_data_c;
            q_owner <= win_idx_c;
            q_valid <= 1'b1;
            gnt     <= N'(onehot(MAX_IDXW'(win_idx_c)));
            if (rot_c) begin
                ptr <= ptr_nxt_c;
            end
        end else begin
            gnt <= '0;
        end
    end

`ifdef REG_ARB_LOCK_EN
    // Burst counter: restarts on a rotation grant, counts locked repeats
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bcnt <= '0;
        end else if (win_c) begin
            bcnt <= rot_c ? BW'(1) : bcnt + BW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_reg_arb.sv
// Directed self-checking bench for reg_arb (N=4, W=8, MAX_BURST=4).
// Follows REG_ARB_LOCK_EN for the lock port and the burst scenario.
module tb_reg_arb;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       valid;
    } exp_t;

    logic        clk;
    logic        n_rst;
    logic [3:0]  req;
    logic [31:0] wdata;
`ifdef REG_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  q_owner;
    logic        q_valid;

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    reg_arb #(
        .N         (4),
        .W         (8),
        .MAX_BURST (4)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .req     (req),
        .wdata   (wdata),
`ifdef REG_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .q_valid (q_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic [7:0] d,
                                input logic [1:0] o, input logic v);
        exp_t e;
        e.gnt = g; e.q = d; e.owner = o; e.valid = v;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".gnt"},     32'(gnt),     32'(e.gnt));
        chk({tag, ".q"},       32'(q),       32'(e.q));
        chk({tag, ".q_owner"}, 32'(q_owner), 32'(e.owner));
        chk({tag, ".q_valid"}, 32'(q_valid), 32'(e.valid));
    endtask

    // Drive req away from the edge, queue the expectation, compare after the edge
    task automatic step(input string tag, input logic [3:0] r, input exp_t e);
        exp_t got;
        req = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check_outputs(tag, got);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge
    task automatic async_reset(input string tag);
        #2;
        n_rst = 1'b0;
        #1;
        check_outputs(tag, mk(4'b0000, 8'h00, 2'd0, 1'b0));
        #2;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        req   = 4'b0000;
        wdata = 32'h0;
`ifdef REG_ARB_LOCK_EN
        lock  = 4'b0000;
`endif
        #12;
        check_outputs("reset", mk(4'b0000, 8'h00, 2'd0, 1'b0));
        #1;
        n_rst = 1'b1;

        // Full contention after reset: strict rotation 0,1,2,3,0
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        step("rr0", 4'b1111, mk(4'b0001, 8'h11, 2'd0, 1'b1));
        step("rr1", 4'b1111, mk(4'b0010, 8'h22, 2'd1, 1'b1));
        step("rr2", 4'b1111, mk(4'b0100, 8'h33, 2'd2, 1'b1));
        step("rr3", 4'b1111, mk(4'b1000, 8'h44, 2'd3, 1'b1));
        step("rr4", 4'b1111, mk(4'b0001, 8'h11, 2'd0, 1'b1));

        // Mid-stream async reset with all requests held; requester 0 first after
        async_reset("mid_rst");
        step("post_rst", 4'b1111, mk(4'b0001, 8'h11, 2'd0, 1'b1));

        // Single write from requester 2, then idle holds the value
        wdata = {8'h99, 8'hA5, 8'h77, 8'h66};
        step("single", 4'b0100, mk(4'b0100, 8'hA5, 2'd2, 1'b1));
        step("single_hold", 4'b0000, mk(4'b0000, 8'hA5, 2'd2, 1'b1));

        // Grant to 3 wraps ptr to 0; then 1 before 3
        wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        step("wrap3", 4'b1000, mk(4'b1000, 8'hD3, 2'd3, 1'b1));
        step("wrap1", 4'b1010, mk(4'b0010, 8'hB1, 2'd1, 1'b1));
        step("wrap3b", 4'b1010, mk(4'b1000, 8'hD3, 2'd3, 1'b1));

        // Idle hold with owner 1, then requester 0 wins from ptr=2
        wdata = {8'h4D, 8'h2B, 8'h3C, 8'h1A};
        step("idle_load", 4'b0010, mk(4'b0010, 8'h3C, 2'd1, 1'b1));
        for (int i = 0; i < 5; i++) begin
            step("idle", 4'b0000, mk(4'b0000, 8'h3C, 2'd1, 1'b1));
        end
        step("idle_wake", 4'b0001, mk(4'b0001, 8'h1A, 2'd0, 1'b1));

        // Two requesters after reset: burst lock or plain alternation
        @(posedge clk);
        #1;
        async_reset("rst_pair");
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef REG_ARB_LOCK_EN
        lock = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step("burst_a", 4'b0011, mk(4'b0001, 8'h11, 2'd0, 1'b1));
        end
        step("burst_other", 4'b0011, mk(4'b0010, 8'h22, 2'd1, 1'b1));
        for (int i = 0; i < 4; i++) begin
            step("burst_b", 4'b0011, mk(4'b0001, 8'h11, 2'd0, 1'b1));
        end
        lock = 4'b0000;
`else
        for (int i = 0; i < 2; i++) begin
            step("alt0", 4'b0011, mk(4'b0001, 8'h11, 2'd0, 1'b1));
            step("alt1", 4'b0011, mk(4'b0010, 8'h22, 2'd1, 1'b1));
        end
`endif
        req = 4'b0000;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
